key_code_fifo_ctrl: RTL

//  Sequences the scan-keyboard read handshake (D_ready/readn) on behalf of the hex operand-entry logic.

---
 rtl/key_code_fifo_ctrl_pkg.sv | 15 +
 rtl/key_code_fifo_ctrl_if.sv | 28 ++
 rtl/key_code_fifo_ctrl_fifo.sv | 56 +++++
 rtl/key_code_fifo_ctrl.sv | 124 ++++++++++++
 4 files changed

// File: rtl/key_code_fifo_ctrl_pkg.sv
// Shared types for the key-code capture path: key code width, handshake FSM states
// and the bounce-filter window length.
package key_pkg;

    typedef logic [4:0] key_code_t;

    typedef enum logic [1:0] {
        IDLE,
        ACK,
        WAIT
    } state_e;

    localparam int unsigned DEDUP_WINDOW = 64;

endpackage

// File: rtl/key_code_fifo_ctrl_if.sv
// Scanner-side handshake plus consumer-side valid/ready stream for key_code_fifo_ctrl.
// slave = controller side, master = environment (scanner + consumer) side.
interface key_code_fifo_ctrl_if
    import key_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) ();

    logic                     D_ready;
    key_code_t                Din;
    logic                     readn;
    key_code_t                code_o;
    logic                     code_valid;
    logic                     code_ready;
    logic [$clog2(DEPTH):0]   level;
    logic                     stuck;

    modport slave (
        input  D_ready, Din, code_ready,
        output readn, code_o, code_valid, level, stuck
    );

    modport master (
        output D_ready, Din, code_ready,
        input  readn, code_o, code_valid, level, stuck
    );

endinterface

// File: rtl/key_code_fifo_ctrl_fifo.sv
// key_fifo: DEPTH x 5-bit first-word-fall-through buffer; head word is always visible on dout_o.
// Caller must not push when full; pops while empty are ignored.
module key_fifo
    import key_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push_i,
    input  key_code_t                din_i,
    input  logic                     pop_i,
    output key_code_t                dout_o,
    output logic                     valid_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int unsigned PW = $clog2(DEPTH);

    key_code_t       mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [PW:0]     level_q;
    logic            pop_eff;

    assign pop_eff = pop_i & (level_q != '0);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= din_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop_eff) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_i, pop_eff})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign valid_o = (level_q != '0);
    assign level_o = level_q;

endmodule

// File: rtl/key_code_fifo_ctrl.sv
// Scanner read handshake (D_ready/readn) feeding a FWFT key-code FIFO, with stuck-D_ready detection.
// Optional bounce filter enabled by defining DEDUP_EN.
module key_code_fifo_ctrl
    import key_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic                  clk,
    input  logic                  rstn,
    key_code_fifo_ctrl_if.slave   bus
);

    localparam int unsigned LW = $clog2(DEPTH) + 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    state_e          state_q, state_d;
    logic            readn_q, readn_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            stuck_q, stuck_d;
    logic            accept;
    logic            push;
    logic            keep;
    logic            full;
    logic [LW-1:0]   level;

    // Full is judged on the registered level, so a same-cycle pop never frees a slot early.
    assign full = (level == LW'(DEPTH));

`ifdef DEDUP_EN
    key_code_t   last_q;
    logic [5:0]  age_q;
    logic        none_q;

    assign keep = none_q | (bus.Din != last_q);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            last_q <= '0;
            age_q  <= '0;
            none_q <= 1'b1;
        end else if (accept) begin
            last_q <= bus.Din;
            age_q  <= '0;
            none_q <= 1'b0;
        end else if (!none_q) begin
            // Window expiry is folded into the "no previous code" flag.
            if (age_q == 6'(DEDUP_WINDOW - 1)) begin
                none_q <= 1'b1;
            end else begin
                age_q <= age_q + 1'b1;
            end
        end
    end
`else
    assign keep = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            readn_q <= 1'b1;
            timer_q <= '0;
            stuck_q <= 1'b0;
        end else begin
            state_q <= state_d;
            readn_q <= readn_d;
            timer_q <= timer_d;
            stuck_q <= stuck_d;
        end
    end

    always_comb begin
        state_d = state_q;
        readn_d = 1'b1;
        timer_d = timer_q;
        stuck_d = stuck_q;
        accept  = 1'b0;
        push    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.D_ready && !full) begin
                    accept  = 1'b1;
                    push    = keep;
                    readn_d = 1'b0;
                    state_d = ACK;
                end
            end
            ACK: begin
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (!bus.D_ready) begin
                    state_d = IDLE;
                end else if (timer_q == TW'(TIMEOUT)) begin
                    stuck_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    key_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push_i  (push),
        .din_i   (bus.Din),
        .pop_i   (bus.code_ready),
        .dout_o  (bus.code_o),
        .valid_o (bus.code_valid),
        .level_o (level)
    );

    assign bus.readn = readn_q;
    assign bus.level = level;
    assign bus.stuck = stuck_q;

endmodule
